// File: rtl/multi.sv
// -----------------------------------------------------------------------------
// multi: 32x32 signed sequential multiplier, 64-bit signed product.
// One radix-2 shift/add step per clock for exactly 32 clocks, so the latency
// does not depend on the operand values.
// The multiplier's sign bit carries weight -2^31 in two's complement.
// For that reason the final step subtracts its partial product instead of
// adding it, and no correction step is needed afterwards.
// -----------------------------------------------------------------------------
module multi (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mlier,
  input  logic [31:0] mcand,
  output logic [63:0] prodt,
  input  logic        start,
  output logic        valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] mlier_sh;   // captured multiplier, shifted right one bit per step
  logic [63:0] mcand_sh;   // sign-extended multiplicand, shifted left one bit per step
  logic [63:0] acc;        // running partial sum
  logic [4:0]  count;      // index of the step being performed (0..31)
  logic        last_step;
  logic [63:0] acc_next;

  // Partial product for one step.
  // It is zero when the multiplier bit is clear.
  // It is negated on the sign-bit step because that bit weighs -2^31.
  function automatic logic [63:0] partial_product(
    input logic        bit_set,
    input logic        negate,
    input logic [63:0] shifted_mcand
  );
    logic [63:0] term;
    if (!bit_set) begin
      term = 64'd0;
    end else if (negate) begin
      term = 64'd0 - shifted_mcand;
    end else begin
      term = shifted_mcand;
    end
    return term;
  endfunction

  // Next accumulator value: the current sum plus this step's partial product.
  always_comb begin
    last_step = 1'b0;
    acc_next  = acc;
    if (count == 5'd31) begin
      last_step = 1'b1;
    end else begin
      last_step = 1'b0;
    end
    acc_next = acc + partial_product(mlier_sh[0], last_step, mcand_sh);
  end

  // Control FSM together with the datapath registers and the registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mlier_sh <= 32'd0;
      mcand_sh <= 64'd0;
      acc      <= 64'd0;
      count    <= 5'd0;
      prodt    <= 64'd0;
      valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            // Capture the operands here; the inputs are not looked at again
            // until the next request.
            mlier_sh <= mlier;
            mcand_sh <= {{32{mcand[31]}}, mcand};
            acc      <= 64'd0;
            count    <= 5'd0;
            state    <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          // start is deliberately ignored here, so a request cannot be aborted.
          acc      <= acc_next;
          mlier_sh <= {1'b0, mlier_sh[31:1]};
          mcand_sh <= {mcand_sh[62:0], 1'b0};
          count    <= count + 5'd1;
          if (last_step) begin
            prodt <= acc_next;
            valid <= 1'b1;
            state <= DONE;
          end else begin
            state <= BUSY;
          end
        end
        DONE: begin
          // Hold the result until the requester drops start. That keeps a
          // start level that is still high from launching a second operation.
          if (!start) begin
            valid <= 1'b0;
            state <= IDLE;
          end else begin
            valid <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi.sv
// -----------------------------------------------------------------------------
// tb_multi: self-checking bench for the multi sequential multiplier.
// The expected values come from plain 64-bit signed arithmetic on the
// operands that were applied.
// -----------------------------------------------------------------------------
module tb_multi;

  logic        clock;
  logic        reset;
  logic [31:0] mlier;
  logic [31:0] mcand;
  logic [63:0] prodt;
  logic        start;
  logic        valid;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  logic [63:0] last_prod;

  multi dut (
    .clock (clock),
    .reset (reset),
    .mlier (mlier),
    .mcand (mcand),
    .prodt (prodt),
    .start (start),
    .valid (valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: the exact signed product, computed with 64-bit arithmetic.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  // Stimulus only: launches one request and reports what happened.
  // lat is the number of edges after the sampling edge until valid was seen.
  // lat is 40 when that bound ran out.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                        input bit scramble, input int extra,
                        output int lat, output logic [63:0] p,
                        output bit held_ok, output bit cleared);
    mlier = a;
    mcand = b;
    start = 1'b1;
    @(posedge clock); #1;                // sampling edge N
    if (!hold) start = 1'b0;
    lat = 0;
    while (valid !== 1'b1 && lat < 40) begin
      if (scramble) begin
        mlier = $urandom;
        mcand = $urandom;
      end
      @(posedge clock); #1;
      lat++;
    end
    p = prodt;
    held_ok = 1'b1;
    repeat (extra) begin
      @(posedge clock); #1;
      if (valid !== 1'b1 || prodt !== p) held_ok = 1'b0;
    end
    start = 1'b0;
    @(posedge clock); #1;
    cleared = (valid === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    mlier = 32'd0;
    mcand = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    chk_cnt++;
    if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid);
    else pass_cnt++;
    chk_cnt++;
    if (prodt !== 64'd0) $display("FAIL reset_prodt: got %h want 0", prodt);
    else pass_cnt++;
    reset = 1'b1;
    @(posedge clock); #1;
    chk_cnt++;
    if (valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", valid);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat;
    logic [63:0] p;
    bit held_ok;
    bit cleared;
    run_op(32'd3, 32'hFFFF_FFFB, 1'b1, 1'b0, 3, lat, p, held_ok, cleared);
    chk_cnt++;
    if (lat != 32) $display("FAIL basic_latency: got %0d want 32", lat);
    else pass_cnt++;
    chk_cnt++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL basic_prodt: got %h want fffffffffffffff1", p);
    else pass_cnt++;
    chk_cnt++;
    if (!held_ok) $display("FAIL done_hold: got dropped want valid/prodt held while start=1");
    else pass_cnt++;
    chk_cnt++;
    if (!cleared) $display("FAIL done_clear: got valid=%b want 0 after start low", valid);
    else pass_cnt++;
    last_prod = p;
  endtask

  task automatic test_corners();
    logic [31:0] ca [4];
    logic [31:0] cb [4];
    logic [63:0] ce [4];
    int lat;
    logic [63:0] p;
    bit held_ok;
    bit cleared;
    ca[0] = 32'h7FFF_FFFF; cb[0] = 32'h7FFF_FFFF; ce[0] = 64'h3FFF_FFFF_0000_0001;
    ca[1] = 32'h8000_0000; cb[1] = 32'h8000_0000; ce[1] = 64'h4000_0000_0000_0000;
    ca[2] = 32'h8000_0000; cb[2] = 32'h7FFF_FFFF; ce[2] = 64'hC000_0000_8000_0000;
    ca[3] = 32'h0000_0000; cb[3] = $urandom;      ce[3] = 64'd0;
    for (int i = 0; i < 4; i++) begin
      run_op(ca[i], cb[i], 1'b1, 1'b0, 0, lat, p, held_ok, cleared);
      chk_cnt++;
      if (p !== ce[i] || lat != 32)
        $display("FAIL corner_%0d: got %h lat %0d want %h lat 32", i, p, lat, ce[i]);
      else pass_cnt++;
      last_prod = p;
    end
  endtask

  task automatic test_start_pulse();
    int lat;
    logic [63:0] p;
    bit held_ok;
    bit cleared;
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = $urandom;
    run_op(a, b, 1'b0, 1'b0, 0, lat, p, held_ok, cleared);
    chk_cnt++;
    if (lat != 32 || p !== ref_mul(a, b))
      $display("FAIL pulse_result: got %h lat %0d want %h lat 32", p, lat, ref_mul(a, b));
    else pass_cnt++;
    chk_cnt++;
    if (!cleared) $display("FAIL pulse_one_cycle: got valid=%b want 0", valid);
    else pass_cnt++;
    last_prod = p;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [63:0] p;
    bit held_ok;
    bit cleared;
    logic [31:0] a;
    logic [31:0] b;
    mlier = 32'h1234_5678;
    mcand = 32'h8765_4321;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (16) @(posedge clock);
    #1;
    chk_cnt++;
    if (prodt !== last_prod || valid !== 1'b0)
      $display("FAIL busy_retain: got %h/%b want %h/0", prodt, valid, last_prod);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    chk_cnt++;
    if (valid !== 1'b0 || prodt !== 64'd0)
      $display("FAIL async_reset: got %h/%b want 0/0", prodt, valid);
    else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (valid === 1'b1) seen++;
    end
    chk_cnt++;
    if (seen != 0) $display("FAIL no_valid_after_abort: got %0d pulses want 0", seen);
    else pass_cnt++;
    a = $urandom;
    b = $urandom;
    run_op(a, b, 1'b1, 1'b0, 0, lat, p, held_ok, cleared);
    chk_cnt++;
    if (lat != 32 || p !== ref_mul(a, b))
      $display("FAIL after_reset: got %h lat %0d want %h lat 32", p, lat, ref_mul(a, b));
    else pass_cnt++;
    last_prod = p;
  endtask

  task automatic test_operand_change();
    int lat;
    logic [63:0] p;
    bit held_ok;
    bit cleared;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 2; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(a, b, 1'b1, 1'b1, 0, lat, p, held_ok, cleared);
      chk_cnt++;
      if (lat != 32 || p !== ref_mul(a, b))
        $display("FAIL operand_change_%0d: got %h lat %0d want %h lat 32", i, p, lat, ref_mul(a, b));
      else pass_cnt++;
      last_prod = p;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] p;
    bit held_ok;
    bit cleared;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(a, b, 1'b1, 1'b0, 0, lat, p, held_ok, cleared);
      chk_cnt++;
      if (lat != 32) $display("FAIL b2b_latency_%0d: got %0d want 32", i, lat);
      else pass_cnt++;
      chk_cnt++;
      if (p !== ref_mul(a, b))
        $display("FAIL b2b_prodt_%0d: got %h want %h (a=%h b=%h)", i, p, ref_mul(a, b), a, b);
      else pass_cnt++;
      chk_cnt++;
      if (!cleared) $display("FAIL b2b_clear_%0d: got valid=%b want 0", i, valid);
      else pass_cnt++;
    end
  endtask

  initial begin
    last_prod = 64'd0;
    test_reset();
    test_basic();
    test_corners();
    test_start_pulse();
    test_reset_mid();
    test_operand_change();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/multi.md
MULTI -- requirements
Module: multi

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32 bits, product width fixed at 64 bits.
REQ-002 SHALL provide ports in this positional order: clock, reset, mlier, mcand, prodt, start, valid.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mlier  input  32  signed two's-complement multiplier operand.
REQ-006 mcand  input  32  signed two's-complement multiplicand operand.
REQ-007 prodt  output  64  signed two's-complement product, registered.
REQ-008 start  input  1  level-sensitive request to begin a multiplication.
REQ-009 valid  output  1  registered flag; high while prodt holds the result of the current request.

Function
REQ-010 SHALL implement a sequential multiplier with three states: IDLE, BUSY, DONE.
REQ-011 IDLE: on a rising edge with start=1, SHALL capture mlier and mcand into internal registers, clear the iteration counter, and go to BUSY (edge N).
REQ-012 Operand inputs SHALL be ignored after capture; changes during BUSY/DONE do not affect the result.
REQ-013 BUSY: SHALL perform exactly one iteration per clock (radix-2 shift/add or Booth step) for 32 iterations, on edges N+1 to N+32.
REQ-014 On edge N+32 SHALL load the exact 64-bit signed product into prodt, set valid=1, and enter DONE; latency is fixed at 32 clocks, independent of operand values.
REQ-015 Product SHALL equal the mathematically exact signed product of the two captured 32-bit operands; no truncation or saturation.
REQ-016 start is ignored during BUSY; deasserting it mid-operation does not abort the operation.
REQ-017 DONE: valid=1 and prodt held for at least one full cycle; on the first rising edge with start=0, SHALL clear valid and return to IDLE.
REQ-018 DONE with start still 1: SHALL remain in DONE (no relaunch) until start is sampled 0.
REQ-019 prodt SHALL retain the last completed result while in IDLE and BUSY; it changes only on the completion edge or reset.
REQ-020 A new operation SHALL start at the earliest on the edge after the return to IDLE; one low cycle of start is sufficient between requests.

Reset
REQ-021 reset=0 SHALL asynchronously force state=IDLE, valid=0, prodt=64'h0, counter and operand registers = 0.
REQ-022 Reset asserted mid-operation SHALL abort it; no valid pulse follows. After release, operation resumes per REQ-011 on the first edge with start=1.

Verification
REQ-023 mlier=3, mcand=-5, start held -> valid rises exactly 32 clocks after the sampling edge, prodt=64'hFFFFFFFFFFFFFFF1.
REQ-024 Corner operands: 7FFFFFFF*7FFFFFFF -> 3FFFFFFF00000001; 80000000*80000000 -> 4000000000000000; 80000000*7FFFFFFF -> C000000080000000; 0*any -> 0.
REQ-025 start high 1 cycle then low during BUSY -> result still delivered at N+32; valid high 1 cycle, then IDLE.
REQ-026 Reset pulse at iteration ~16 -> valid=0, prodt=0 immediately; no valid pulse; next start yields a correct result.
REQ-027 20 back-to-back random signed pairs, start high 33 cycles then low 1 cycle -> one valid rising edge per request, prodt equals the reference signed product each time.
REQ-028 Change mlier/mcand during BUSY -> prodt reflects the operands captured at edge N.
